// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that lets N_REQ byte sources share a single uart_tx.
// One byte is forwarded per grant. The arbiter then waits for the
// transmitter's busy flag to drop before it arbitrates again.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   When it is defined, a requester keeps the grant until it sends a byte with
//   req_last=1. An idle timeout (LOCK_TIMEOUT cycles with req[grant]=0) drops
//   the lock and pulses lock_abort. When it is undefined, req_last is ignored
//   and locked/lock_abort are tied to 0.
//
// Parameters:
//   N_REQ         number of requesters (2..8)
//   LOCK_TIMEOUT  idle cycles before a held lock is abandoned (1..65535)
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   req         per-requester byte valid
//   req_data    requester i's byte on bits [8i+7:8i]
//   req_last    last byte of a packet (lock build only)
//   ack         one-cycle pulse, requester's byte consumed
//   tx_data     byte to the transmitter
//   tx_we       one-cycle write strobe to the transmitter
//   tx_busy     transmitter is shifting a frame
//   grant       index of the requester currently or last served
//   locked      grant held for a multi-byte packet
//   lock_abort  one-cycle pulse, lock dropped on timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         ack,
    output logic [7:0]               tx_data,
    output logic                     tx_we,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant,
    output logic                     locked,
    output logic                     lock_abort
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_ack;
    logic [7:0]       r_tx_data;
    logic             r_tx_we;
    logic [GW-1:0]    r_grant;

    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [GW-1:0]    w_win;
    int               w_idx;

`ifdef UART_ARB_LOCK_EN
    logic        r_locked;
    logic        r_lock_abort;
    logic [15:0] r_idle_cnt;

    // While locked, only the current owner may be picked. The search below
    // starts at grant+1 and wraps, so it ends on grant itself.
    assign w_elig     = r_locked ? (req & (N_REQ'(1) << r_grant)) : req;
    assign locked     = r_locked;
    assign lock_abort = r_lock_abort;
`else
    logic w_unused_cfg;

    assign w_elig       = req;
    assign locked       = 1'b0;
    assign lock_abort   = 1'b0;
    assign w_unused_cfg = ^req_last ^ (LOCK_TIMEOUT == 0);
`endif

    assign ack     = r_ack;
    assign tx_data = r_tx_data;
    assign tx_we   = r_tx_we;
    assign grant   = r_grant;

    // Round-robin search: the first eligible requester after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_grant;
        w_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = int'(r_grant) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ack     <= '0;
            r_tx_data <= '0;
            r_tx_we   <= 1'b0;
            r_grant   <= GW'(N_REQ - 1);
`ifdef UART_ARB_LOCK_EN
            r_locked     <= 1'b0;
            r_lock_abort <= 1'b0;
            r_idle_cnt   <= '0;
`endif
        end else begin
`ifdef UART_ARB_LOCK_EN
            r_lock_abort <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found && !tx_busy) begin
                        r_tx_data <= req_data[8*w_win +: 8];
                        r_tx_we   <= 1'b1;
                        r_ack     <= N_REQ'(1) << w_win;
                        r_grant   <= w_win;
                        r_state   <= S_LOAD;
                    end
`ifdef UART_ARB_LOCK_EN
                    // The owner's absence is counted only while we wait in IDLE.
                    if (r_locked) begin
                        if (req[r_grant]) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt == 16'(LOCK_TIMEOUT - 1)) begin
                            r_locked     <= 1'b0;
                            r_lock_abort <= 1'b1;
                            r_idle_cnt   <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 16'd1;
                        end
                    end
`endif
                end
                S_LOAD: begin
                    r_tx_we <= 1'b0;
                    r_ack   <= '0;
`ifdef UART_ARB_LOCK_EN
                    // req_last is still stable here because the requester
                    // only moves on in the cycle after ack.
                    r_locked   <= !req_last[r_grant];
                    r_idle_cnt <= '0;
`endif
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '1;
    logic [N-1:0]   ack;
    logic [7:0]     tx_data;
    logic           tx_we;
    logic           tx_busy;
    logic [1:0]     grant;
    logic           locked;
    logic           lock_abort;

    logic hold_busy = 1'b0;
    int   busy_cnt  = 0;
    int   busy_len  = 4;

    int total = 0;
    int bad   = 0;

    // Requester-side byte queues (what is presented) and reference-model queues.
    logic [7:0] rq_data [N][$];
    bit         rq_last [N][$];
    logic [7:0] mq_data [N][$];
    bit         mq_last [N][$];
    int         order [$];
    int         model_last   = N - 1;
    bit         model_locked = 1'b0;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .ack        (ack),
        .tx_data    (tx_data),
        .tx_we      (tx_we),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .locked     (locked),
        .lock_abort (lock_abort)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for busy_len cycles starting the cycle after tx_we.
    always @(posedge clk) begin
        if (tx_we === 1'b1) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = hold_busy || (busy_cnt > 0);

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int i, input logic [7:0] b, input bit last);
        rq_data[i].push_back(b);
        rq_last[i].push_back(last);
        mq_data[i].push_back(b);
        mq_last[i].push_back(last);
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (rq_data[i].size() > 0) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = rq_data[i][0];
                req_last[i]       = rq_last[i][0];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b1;
            end
        end
    endtask

    // Round robin over requesters that still have bytes; a locked owner keeps the turn.
    function automatic int pick();
        int j;
        if (model_locked) return (mq_data[model_last].size() > 0) ? model_last : -1;
        for (int k = 1; k <= N; k++) begin
            j = (model_last + k) % N;
            if (mq_data[j].size() > 0) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        req       = '0;
        hold_busy = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset  = 1'b0;
        model_last   = N - 1;
        model_locked = 1'b0;
    endtask

    task automatic run_engine(input int lo, input int hi);
        int         remaining;
        int         since_we;
        int         exp;
        int         cyc;
        bit         prev_busy;
        bit         pend [N];
        bit         lst;
        logic [7:0] b;
        remaining = 0;
        since_we  = 100;
        cyc       = 0;
        for (int i = 0; i < N; i++) begin
            remaining += mq_data[i].size();
            pend[i] = 1'b0;
        end
        order.delete();
        prev_busy = tx_busy;
        present();
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (pend[i] && rq_data[i].size() > 0) begin
                    void'(rq_data[i].pop_front());
                    void'(rq_last[i].pop_front());
                end
                pend[i] = ack[i];
            end
            check("abort_quiet", 32'(lock_abort), 32'd0);
            if (tx_we) begin
                busy_len = $urandom_range(hi, lo);
                check("busy_low_before_we", 32'(prev_busy), 32'd0);
                check("locked_at_we", 32'(locked), 32'(model_locked));
                exp = pick();
                if (exp < 0) begin
                    check("unexpected_we", 32'(tx_we), 32'd0);
                end else begin
                    b   = mq_data[exp].pop_front();
                    lst = mq_last[exp].pop_front();
                    check("rr_grant", 32'(grant), 32'(exp));
                    check("rr_data", 32'(tx_data), 32'(b));
                    check("rr_ack", 32'(ack), 32'(1 << exp));
                    order.push_back(exp);
                    model_last = exp;
`ifdef UART_ARB_LOCK_EN
                    model_locked = !lst;
`endif
                    remaining--;
                end
                since_we = 0;
            end else begin
                check("ack_without_we", 32'(ack), 32'd0);
                since_we++;
            end
            prev_busy = tx_busy;
            present();
            if (remaining == 0 && since_we >= 2 && !tx_busy) break;
        end
        check("all_bytes_sent", 32'(remaining), 32'd0);
    endtask

    initial begin
        int gap;
        int k_abort;
        bit seen;
        int fair_exp [5];
        int lock_exp [5];
        int n;
        fair_exp = '{0, 1, 2, 3, 0};
        lock_exp = '{0, 1, 1, 1, 0};

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_we", 32'(tx_we), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant), 32'd3);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_abort", 32'(lock_abort), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single requester: one-cycle latency, then the next byte waits for the frame.
        req = 4'b0100; req_data = 32'h0041_0000; req_last = '1; busy_len = 6;
        @(posedge clk); #1;
        check("t1_we", 32'(tx_we), 32'd1);
        check("t1_ack", 32'(ack), 32'd4);
        check("t1_data", 32'(tx_data), 32'h41);
        check("t1_grant", 32'(grant), 32'd2);
        @(posedge clk); #1;
        req_data = 32'h0042_0000;
        gap = 0; seen = 1'b0;
        // LOAD, 6 busy cycles in SEND, one SEND cycle that sees idle, one IDLE cycle.
        for (int c = 2; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (tx_we) begin seen = 1'b1; gap = c; end
        end
        check("t1_gap", 32'(gap), 32'd9);
        check("t1_data2", 32'(tx_data), 32'h42);
        @(posedge clk); #1;
        req = '0;
        repeat (12) @(posedge clk);
        #1;

        // Busy held high in IDLE blocks the issue; release gives tx_we next cycle.
        hold_busy = 1'b1; req = 4'b0010; req_data = 32'h0000_7700;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (tx_we) seen = 1'b1;
        end
        check("t3_blocked", 32'(seen), 32'd0);
        hold_busy = 1'b0;
        @(posedge clk); #1;
        check("t3_we", 32'(tx_we), 32'd1);
        check("t3_ack", 32'(ack), 32'd2);
        check("t3_data", 32'(tx_data), 32'h77);
        @(posedge clk); #1;
        req = '0;
        repeat (12) @(posedge clk);
        #1;

        // Fairness with all four requesters active.
        do_reset();
        add(0, 8'h10, 1'b1); add(1, 8'h11, 1'b1); add(2, 8'h12, 1'b1);
        add(3, 8'h13, 1'b1); add(0, 8'h14, 1'b1);
        run_engine(20, 20);
        check("fair_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("fair_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(fair_exp[i]));

        // Randomized traffic against the queue model.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                n = $urandom_range(4, 0);
                repeat (n) add(i, 8'($urandom), 1'b1);
            end
            run_engine(1, 6);
        end

        // Reset while SEND: outputs return to reset values at once.
        repeat (4) @(posedge clk);
        #1;
        req = 4'b0100; req_data = 32'h0055_0000; busy_len = 10;
        @(posedge clk); #1;
        check("rs_we", 32'(tx_we), 32'd1);
        @(posedge clk); #1;
        req = '0;
        reset = 1'b1;
        #1;
        check("rs_ack", 32'(ack), 32'd0);
        check("rs_we0", 32'(tx_we), 32'd0);
        check("rs_data", 32'(tx_data), 32'd0);
        check("rs_grant", 32'(grant), 32'd3);
        check("rs_locked", 32'(locked), 32'd0);
        check("rs_abort", 32'(lock_abort), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_last = N - 1; model_locked = 1'b0;
        add(2, 8'hA2, 1'b1); add(0, 8'hA0, 1'b1);
        run_engine(3, 3);
        check("rs_first", (order.size() > 0) ? 32'(order[0]) : 32'hFFFF_FFFF, 32'd0);

`ifdef UART_ARB_LOCK_EN
        // Packet lock: requester 1's three-byte packet is not interrupted.
        do_reset();
        add(0, 8'h01, 1'b1); add(0, 8'h02, 1'b1);
        add(1, 8'h31, 1'b0); add(1, 8'h32, 1'b0); add(1, 8'h33, 1'b1);
        run_engine(5, 5);
        for (int i = 0; i < 5; i++)
            check("lock_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(lock_exp[i]));

        // Lock timeout: the owner goes quiet; the abort is seen 9 cycles after the
        // transmitter goes idle (SEND->IDLE, then 8 idle cycles).
        do_reset();
        add(3, 8'h3F, 1'b0);
        run_engine(4, 4);
        check("to_locked", 32'(locked), 32'd1);
        req[0] = 1'b1; req_data[7:0] = 8'h05; req_last[0] = 1'b1;
        k_abort = 0; seen = 1'b0;
        for (int k = 1; k <= 20 && k_abort == 0; k++) begin
            @(posedge clk); #1;
            if (tx_we) seen = 1'b1;
            if (lock_abort) begin
                k_abort = k;
                check("to_unlocked", 32'(locked), 32'd0);
            end
        end
        check("to_gap", 32'(k_abort), 32'd9);
        check("to_no_we_locked", 32'(seen), 32'd0);
        @(posedge clk); #1;
        check("to_abort_pulse", 32'(lock_abort), 32'd0);
        check("to_we", 32'(tx_we), 32'd1);
        check("to_ack", 32'(ack), 32'd1);
        check("to_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;
        req = '0;
        repeat (8) @(posedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
